// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential unsigned divider (DIVU/REMU datapath).
package seq_div_pkg;

  // Default operand width of the M-extension datapath.
  localparam int W_DEF = 64;

  // Quotient reported for a zero divisor (all ones, RISC-V DIVU semantics).
  localparam logic [W_DEF-1:0] DIV_ZERO_Q = {W_DEF{1'b1}};

  // Divider sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1
  } state_t;

endpackage

// File: rtl/seq_div_step.sv
// One restoring shift-subtract iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor and keep the result if no borrow.
module seq_div_step
  import seq_div_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] p,
  input  logic         q_msb,
  input  logic [W-1:0] d,
  output logic [W-1:0] p_next,
  output logic         q_bit
);

  logic [W:0] t_s;

  // Trial subtraction in W+1 bits; the top bit is the borrow (negative result).
  always_comb begin
    t_s = {p, q_msb} - {1'b0, d};
    if (t_s[W] == 1'b0) begin
      q_bit  = 1'b1;
      p_next = t_s[W-1:0];
    end else begin
      // Restore: the shifted value is below d, so it fits in W bits.
      q_bit  = 1'b0;
      p_next = {p[W-2:0], q_msb};
    end
  end

endmodule

// File: rtl/seq_div.sv
// Sequential unsigned divider: one quotient bit per clock, quotient and
// remainder registered, divide-by-zero handled without running the loop.
module seq_div
  import seq_div_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int CNTW = 7
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         L,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] q,
  output logic [W-1:0] r,
  output logic         busy,
  output logic         done,
  output logic         dz
);

  state_t          state_r;
  logic [CNTW-1:0] cnt_r;
  // The partial remainder stays below the divisor between iterations, so
  // its (W+1)-th bit is always zero and only the low W bits are stored.
  logic [W-1:0]    p_r;
  logic [W-1:0]    q_sr_r;
  logic [W-1:0]    d_r;
  logic            dzp_r;   // zero-divisor result due on the next edge
  logic [W-1:0]    q_r;
  logic [W-1:0]    r_r;
  logic            busy_r;
  logic            done_r;
  logic            dz_r;

  logic [W-1:0]    p_nxt_s;
  logic            q_bit_s;

  seq_div_step #(.W(W)) u_step (
    .p      (p_r),
    .q_msb  (q_sr_r[W-1]),
    .d      (d_r),
    .p_next (p_nxt_s),
    .q_bit  (q_bit_s)
  );

  // Sequencer: load/abort on L, iterate in RUN, publish results with a done pulse.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      p_r     <= '0;
      q_sr_r  <= '0;
      d_r     <= '0;
      dzp_r   <= 1'b0;
      q_r     <= '0;
      r_r     <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      dz_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (L) begin
        // A load in any state discards whatever was in flight.
        d_r    <= b;
        q_sr_r <= a;
        p_r    <= '0;
        cnt_r  <= '0;
        if (b != '0) begin
          state_r <= ST_RUN;
          busy_r  <= 1'b1;
          dzp_r   <= 1'b0;
        end else begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          dzp_r   <= 1'b1;
        end
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (dzp_r) begin
              q_r    <= {W{1'b1}};
              r_r    <= q_sr_r;
              dz_r   <= 1'b1;
              done_r <= 1'b1;
              dzp_r  <= 1'b0;
            end else begin
              dzp_r  <= 1'b0;
            end
          end
          ST_RUN: begin
            p_r    <= p_nxt_s;
            q_sr_r <= {q_sr_r[W-2:0], q_bit_s};
            cnt_r  <= cnt_r + {{(CNTW-1){1'b0}}, 1'b1};
            if (cnt_r == CNTW'(W-1)) begin
              q_r     <= {q_sr_r[W-2:0], q_bit_s};
              r_r     <= p_nxt_s;
              dz_r    <= 1'b0;
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
              state_r <= ST_IDLE;
            end else begin
              busy_r  <= 1'b1;
            end
          end
          default: begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign q    = q_r;
  assign r    = r_r;
  assign busy = busy_r;
  assign done = done_r;
  assign dz   = dz_r;

endmodule

// File: tb/tb_seq_div.sv
// Scoreboard bench for seq_div: stimulus pushes expected results, a monitor
// pops and compares on every done pulse, including the cycle it arrived.
module tb_seq_div;

  localparam int W = 64;

  logic         Clk = 1'b0;
  logic         Rst = 1'b1;
  logic         L   = 1'b0;
  logic [W-1:0] a   = '0;
  logic [W-1:0] b   = '0;
  logic [W-1:0] q, r;
  logic         busy, done, dz;

  seq_div #(.W(W), .CNTW(7)) dut (
    .Clk(Clk), .Rst(Rst), .L(L), .a(a), .b(b),
    .q(q), .r(r), .busy(busy), .done(done), .dz(dz)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         edz;
    int           ecyc;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   n_chk    = 0;
  int   n_pass   = 0;
  int   done_cnt = 0;

  // Edge counter used to check latency.
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp_v);
    n_chk++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp_v);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge Clk) begin
    if (!Rst && done) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("q", q, e.eq);
        chk("r", r, e.er);
        chk("dz", {63'd0, dz}, {63'd0, e.edz});
        chk("latency", 64'(cyc), 64'(e.ecyc));
      end
    end
  end

  // Issue a load at the current negedge; returns at the next negedge.
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
    exp_t e;
    e.eq   = eq;
    e.er   = er;
    e.edz  = edz;
    e.ecyc = cyc + 1 + ((bv == 64'd0) ? 1 : W);
    sb.push_back(e);
    L = 1'b1;
    a = av;
    b = bv;
    @(negedge Clk);
    L = 1'b0;
  endtask

  // Wait (bounded) for a done pulse, counting busy cycles on the way.
  task automatic run_wait(output int bcnt);
    bit seen;
    bcnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (busy) bcnt++;
      if (done) seen = 1'b1;
      else @(negedge Clk);
    end
    if (!seen) begin
      chk("timeout", 64'd0, 64'd1);
      sb.delete();
    end
  endtask

  initial begin
    int bc;
    int d0;
    logic [W-1:0] ra, rb;

    // Reset state
    repeat (3) @(negedge Clk);
    chk("rst_q", q, 64'd0);
    chk("rst_r", r, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_dz", {63'd0, dz}, 64'd0);
    Rst = 1'b0;
    @(negedge Clk);

    // 1) 100 / 7
    issue(64'd100, 64'd7, 64'd14, 64'd2, 1'b0);
    run_wait(bc);
    chk("busy_cycles_100_7", 64'(bc), 64'd64);
    @(negedge Clk);
    chk("done_one_cycle", {63'd0, done}, 64'd0);
    chk("q_hold", q, 64'd14);

    // 2) divide by zero
    issue(64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1'b1);
    run_wait(bc);
    chk("busy_cycles_dz", 64'(bc), 64'd0);
    @(negedge Clk);
    chk("dz_hold", {63'd0, dz}, 64'd1);

    // 3) all ones / 1, then a < b
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0);
    run_wait(bc);
    issue(64'd3, 64'd10, 64'd0, 64'd3, 1'b0);
    run_wait(bc);
    issue(64'd77, 64'd77, 64'd1, 64'd0, 1'b0);
    run_wait(bc);

    // 4) abort at cycle 20 by a new load
    @(negedge Clk);
    issue(64'd1000, 64'd3, 64'd333, 64'd1, 1'b0);
    repeat (19) @(negedge Clk);
    void'(sb.pop_back());
    issue(64'd81, 64'd9, 64'd9, 64'd0, 1'b0);
    run_wait(bc);
    chk("busy_cycles_restart", 64'(bc), 64'd64);
    @(negedge Clk);

    // 5) reset in the middle of an operation
    issue(64'd1000, 64'd7, 64'd142, 64'd6, 1'b0);
    repeat (29) @(negedge Clk);
    Rst = 1'b1;
    sb.delete();
    @(negedge Clk);
    chk("midrst_q", q, 64'd0);
    chk("midrst_r", r, 64'd0);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_done", {63'd0, done}, 64'd0);
    Rst = 1'b0;
    d0 = done_cnt;
    repeat (80) @(negedge Clk);
    chk("no_done_after_rst", 64'(done_cnt), 64'(d0));
    // Load and reset together: reset wins
    Rst = 1'b1;
    L   = 1'b1;
    a   = 64'd9;
    b   = 64'd3;
    @(negedge Clk);
    L   = 1'b0;
    Rst = 1'b0;
    chk("ldrst_busy", {63'd0, busy}, 64'd0);
    repeat (70) @(negedge Clk);
    chk("ldrst_no_done", 64'(done_cnt), 64'(d0));
    chk("ldrst_busy_late", {63'd0, busy}, 64'd0);

    // 6) back-to-back operands with a / and % reference
    ra = 64'h8000_0000_0000_0001;
    rb = 64'd3;
    issue(ra, rb, ra / rb, ra % rb, 1'b0);
    for (int i = 0; i < 150; i++) begin
      run_wait(bc);
      ra = {$urandom, $urandom};
      case (i % 5)
        0:       rb = 64'd0;
        1:       rb = 64'($urandom_range(1, 255));
        2:       begin ra = ra >> 8; rb = ra + 64'd1; end
        3:       rb = {1'b1, 31'($urandom), 32'($urandom)};
        default: rb = {32'd0, $urandom} | 64'd1;
      endcase
      if (rb == 64'd0) issue(ra, rb, 64'hFFFF_FFFF_FFFF_FFFF, ra, 1'b1);
      else             issue(ra, rb, ra / rb, ra % rb, 1'b0);
    end
    run_wait(bc);
    @(negedge Clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
